// File: rtl/fpu_microcode_arbiter_if.sv
// Requester and sequencer signal bundle for the FPU microcode arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fpu_microcode_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  // Requester side
  logic [NUM_REQ-1:0]    req_invoke;
  logic [NUM_REQ*12-1:0] req_addr;
  logic [NUM_REQ*80-1:0] req_operand;
  logic [NUM_REQ-1:0]    req_done;
  logic [79:0]           req_result;
  logic [1:0]            req_quadrant;
  logic                  req_error;

  // Sequencer side
  logic                  mc_invoke;
  logic [11:0]           mc_addr;
  logic [79:0]           mc_operand_a;
  logic                  mc_done;
  logic [79:0]           mc_result;
  logic [1:0]            mc_quadrant;
  logic                  mc_error;

  modport slave (
    input  req_invoke, req_addr, req_operand,
    input  mc_done, mc_result, mc_quadrant, mc_error,
    output req_done, req_result, req_quadrant, req_error,
    output mc_invoke, mc_addr, mc_operand_a
  );

  modport master (
    output req_invoke, req_addr, req_operand,
    output mc_done, mc_result, mc_quadrant, mc_error,
    input  req_done, req_result, req_quadrant, req_error,
    input  mc_invoke, mc_addr, mc_operand_a
  );
endinterface

// File: rtl/fpu_microcode_arbiter.sv
// Round-robin arbiter sharing one FPU microcode sequencer port between NUM_REQ
// requesters, one operation at a time, with a per-operation timeout.
module fpu_microcode_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fpu_microcode_arbiter_if.slave bus,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] load_en;
  logic [11:0]        hold_addr_q [NUM_REQ];
  logic [79:0]        hold_op_q   [NUM_REQ];
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [79:0]        result_q, result_d;
  logic [1:0]         quad_q, quad_d;
  logic               error_q, error_d;

  logic               sel_valid;
  logic [2:0]         sel_idx;
  logic [11:0]        grant_addr;
  logic [79:0]        grant_op;

  // Round-robin pick: first pending index above last_grant, then wrap to the low indices.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_valid && pending_q[i] && (3'(i) > last_grant_q)) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_valid && pending_q[i] && (3'(i) <= last_grant_q)) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    grant_op   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        grant_addr = hold_addr_q[i];
        grant_op   = hold_op_q[i];
      end
    end
  end

  // The request in RESPOND is retired here; a fresh invoke from it in that cycle re-arms it.
  always_comb begin
    pending_d = pending_q;
    load_en   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_q == StRespond) && (grant_q == 3'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (bus.req_invoke[i] &&
          (!pending_q[i] || ((state_q == StRespond) && (grant_q == 3'(i))))) begin
        pending_d[i] = 1'b1;
        load_en[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    result_d     = result_q;
    quad_d       = quad_q;
    error_d      = error_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (bus.mc_done) begin
          result_d = bus.mc_result;
          quad_d   = bus.mc_quadrant;
          error_d  = bus.mc_error;
          state_d  = StRespond;
        end else if (timer_q == TimerLast) begin
          result_d = '0;
          quad_d   = '0;
          error_d  = 1'b1;
          state_d  = StRespond;
        end
      end
      StRespond: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      timer_q      <= '0;
      result_q     <= '0;
      quad_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      result_q     <= result_d;
      quad_q       <= quad_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hold_addr_q[i] <= '0;
        hold_op_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (load_en[i]) begin
          hold_addr_q[i] <= bus.req_addr[i*12 +: 12];
          hold_op_q[i]   <= bus.req_operand[i*80 +: 80];
        end
      end
    end
  end

  // All handshake outputs decode from the state register so reset clears them at once.
  always_comb begin
    busy             = (state_q != StIdle);
    grant_id         = grant_q;
    bus.mc_invoke    = (state_q == StIssue);
    bus.mc_addr      = (state_q == StIssue) ? grant_addr : '0;
    bus.mc_operand_a = (state_q == StIssue) ? grant_op : '0;
    bus.req_done     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_done[i] = (state_q == StRespond) && (grant_q == 3'(i));
    end
    bus.req_result   = (state_q == StRespond) ? result_q : '0;
    bus.req_quadrant = (state_q == StRespond) ? quad_q : '0;
    bus.req_error    = (state_q == StRespond) && error_q;
  end

endmodule
